// File: rtl/memory_access_controller.sv
// Memory bus sequencer: arbitrates instruction fetch against LDR/STR data accesses
// and drives one registered read or write transaction at a time onto the memory bus.
module memory_access_controller #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned PC_W        = 8,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [PC_W-1:0]   pc_addr,
   output logic              fetch_ack,
   output logic [DATA_W-1:0] instr_out,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_ack,
   output logic [DATA_W-1:0] data_rdata,
   output logic              busy,
   output logic              sel_add_bus,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic              last_data_q, last_data_d;
   logic              gnt_data_q, gnt_data_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              fetch_ack_q, fetch_ack_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic              data_ack_q, data_ack_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              busy_q, busy_d;
   logic              sel_q, sel_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_re_q, mem_re_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              grant_data;
   logic              capture;

   // Next state, transaction latches, and outputs derived from the upcoming state
   always_comb begin
      state_d     = state_q;
      last_data_d = last_data_q;
      gnt_data_d  = gnt_data_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      instr_d     = instr_q;
      rdata_d     = rdata_q;
      grant_data  = 1'b0;
      capture     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (fetch_req || data_req) begin
               // Data wins a tie unless it won the previous tie-capable grant
               grant_data  = data_req && (!fetch_req || !last_data_q);
               gnt_data_d  = grant_data;
               last_data_d = grant_data;
               addr_d      = grant_data ? data_addr : ADDR_W'(pc_addr);
               we_d        = grant_data && data_we;
               wdata_d     = data_wdata;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (we_q) begin
               state_d = S_DONE;
            end else begin
               cnt_d = CNT_W'(MEM_LATENCY - 1);
               if (MEM_LATENCY == 1) begin
                  capture = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               capture = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (capture) begin
         if (gnt_data_q) rdata_d = mem_rdata;
         else            instr_d = mem_rdata;
      end

      busy_d      = (state_d != S_IDLE);
      sel_d       = (state_d != S_IDLE) && gnt_data_d;
      mem_addr_d  = (state_d != S_IDLE) ? addr_d : '0;
      mem_re_d    = (state_d == S_ISSUE) && !we_d;
      mem_we_d    = (state_d == S_ISSUE) && we_d;
      mem_wdata_d = ((state_d == S_ISSUE) && we_d) ? wdata_d : '0;
      fetch_ack_d = (state_d == S_DONE) && !gnt_data_d;
      data_ack_d  = (state_d == S_DONE) && gnt_data_d;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         last_data_q <= 1'b0;
         gnt_data_q  <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         fetch_ack_q <= 1'b0;
         instr_q     <= '0;
         data_ack_q  <= 1'b0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
         sel_q       <= 1'b0;
         mem_addr_q  <= '0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         last_data_q <= last_data_d;
         gnt_data_q  <= gnt_data_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         fetch_ack_q <= fetch_ack_d;
         instr_q     <= instr_d;
         data_ack_q  <= data_ack_d;
         rdata_q     <= rdata_d;
         busy_q      <= busy_d;
         sel_q       <= sel_d;
         mem_addr_q  <= mem_addr_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign fetch_ack   = fetch_ack_q;
   assign instr_out   = instr_q;
   assign data_ack    = data_ack_q;
   assign data_rdata  = rdata_q;
   assign busy        = busy_q;
   assign sel_add_bus = sel_q;
   assign mem_addr    = mem_addr_q;
   assign mem_re      = mem_re_q;
   assign mem_we      = mem_we_q;
   assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_memory_access_controller.sv
// Bench for memory_access_controller at latencies 1, 2 and 3: random requesters and a
// transaction-level model that expands each grant into its expected per-cycle bus trace.
module tb_memory_access_controller;

   localparam int unsigned NCYC = 1500;

   typedef struct packed {
      logic        busy;
      logic        sel;
      logic        re;
      logic        we;
      logic        fack;
      logic        dack;
      logic        chk_addr;
      logic        chk_wdata;
      logic        upd_rd;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] rval;
   } exp_t;

   logic        clk;
   int unsigned total = 0;
   int unsigned bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Power-on memory contents; two words preset to the values the directed traffic uses
   function automatic logic [31:0] seed_val(input logic [15:0] a);
      if (a == 16'h003C) return 32'hE3A01005;
      if (a == 16'h00F0) return 32'h0000002A;
      return {~a, a} ^ 32'h5A5A_0F0F;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   for (genvar g = 0; g < 3; g++) begin : g_lat
      localparam int unsigned LAT = g + 1;

      logic        rst, fetch_req, fetch_ack, data_req, data_we, data_ack;
      logic        busy, sel_add_bus, mem_re, mem_we;
      logic [7:0]  pc_addr;
      logic [15:0] data_addr, mem_addr;
      logic [31:0] instr_out, data_wdata, data_rdata, mem_wdata, mem_rdata;
      bit          done_f;

      memory_access_controller #(
         .ADDR_W(16), .PC_W(8), .DATA_W(32), .MEM_LATENCY(LAT)
      ) u_dut (
         .clk(clk), .rst(rst),
         .fetch_req(fetch_req), .pc_addr(pc_addr), .fetch_ack(fetch_ack), .instr_out(instr_out),
         .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
         .data_ack(data_ack), .data_rdata(data_rdata), .busy(busy), .sel_add_bus(sel_add_bus),
         .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
         .mem_rdata(mem_rdata)
      );

      initial begin : run
         exp_t        q[$];
         exp_t        e, t;
         logic [31:0] mdl_mem [logic [15:0]];
         logic [31:0] bus_mem [logic [15:0]];
         logic [7:0]  f_tab [4];
         logic [15:0] d_addr_tab [4];
         logic        d_we_tab [4];
         logic [31:0] d_wd_tab [4];
         logic [31:0] m_instr, m_rdata, rv;
         logic [15:0] a, rd_addr;
         logic        rst_prev, last_data, cur_idle, rnd_phase, gd, wr;
         logic        f_gnt, d_gnt, f_drop, d_drop, rd_pend, wait_rst_done;
         int          rd_cd, fi, di, acks;
         string       p;

         f_tab      = '{8'h3C, 8'h40, 8'h3C, 8'h41};
         d_we_tab   = '{1'b1, 1'b0, 1'b1, 1'b0};
         d_addr_tab = '{16'h1234, 16'h00F0, 16'h0040, 16'h1234};
         d_wd_tab   = '{32'hDEADBEEF, 32'h0, 32'hCAFEF00D, 32'h0};

         rst = 1'b1; fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
         pc_addr = '0; data_addr = '0; data_wdata = '0; mem_rdata = '0;
         rst_prev = 1'b1; last_data = 1'b0; m_instr = '0; m_rdata = '0;
         f_gnt = 1'b0; d_gnt = 1'b0; f_drop = 1'b0; d_drop = 1'b0;
         rd_pend = 1'b0; rd_cd = 0; rd_addr = '0; wait_rst_done = 1'b0;
         fi = 0; di = 0; acks = 0;

         for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            p = $sformatf("L%0d c%0d", LAT, cyc);

            // Expected outputs for this cycle
            e        = '0;
            cur_idle = 1'b0;
            if (rst_prev) begin
               q.delete();
               m_instr     = '0;
               m_rdata     = '0;
               e.chk_addr  = 1'b1;
               e.chk_wdata = 1'b1;
               cur_idle    = 1'b1;
            end else if (q.size() != 0) begin
               e = q.pop_front();
            end else begin
               cur_idle = 1'b1;
            end
            if (e.fack) m_instr = e.rval;
            if (e.dack && e.upd_rd) m_rdata = e.rval;
            if (e.fack || e.dack) acks++;

            check_eq({p, " busy"},        32'(busy),        32'(e.busy));
            check_eq({p, " sel_add_bus"}, 32'(sel_add_bus), 32'(e.sel));
            check_eq({p, " mem_re"},      32'(mem_re),      32'(e.re));
            check_eq({p, " mem_we"},      32'(mem_we),      32'(e.we));
            check_eq({p, " fetch_ack"},   32'(fetch_ack),   32'(e.fack));
            check_eq({p, " data_ack"},    32'(data_ack),    32'(e.dack));
            check_eq({p, " instr_out"},   instr_out,        m_instr);
            check_eq({p, " data_rdata"},  data_rdata,       m_rdata);
            if (e.chk_addr)  check_eq({p, " mem_addr"},  32'(mem_addr), 32'(e.addr));
            if (e.chk_wdata) check_eq({p, " mem_wdata"}, mem_wdata,     e.wdata);

            // Memory: writes land on the strobe; read data is valid only in the capture cycle
            if (mem_we) bus_mem[mem_addr] = mem_wdata;
            if (mem_re) begin
               rd_pend = 1'b1;
               rd_cd   = LAT - 1;
               rd_addr = mem_addr;
            end else if (rd_pend && rd_cd != 0) begin
               rd_cd--;
            end
            if (rd_pend && rd_cd == 0) begin
               mem_rdata = bus_mem.exists(rd_addr) ? bus_mem[rd_addr] : seed_val(rd_addr);
               rd_pend   = 1'b0;
            end else begin
               mem_rdata = $urandom;
            end

            // Inputs for this cycle
            rnd_phase = (acks >= 4);
            rst = (cyc < 2) || (rnd_phase && $urandom_range(0, 79) == 0);
            if (rnd_phase && !wait_rst_done && e.busy && e.sel && !e.re && !e.we && !e.dack) begin
               rst           = 1'b1;
               wait_rst_done = 1'b1;
            end

            if (rst) begin
               fetch_req = 1'b0; data_req = 1'b0;
               f_gnt = 1'b0; d_gnt = 1'b0; f_drop = 1'b0; d_drop = 1'b0;
            end else begin
               if (e.fack) begin
                  f_gnt  = 1'b0;
                  f_drop = 1'b1;
               end else if (f_drop) begin
                  fetch_req = 1'b0;
                  f_drop    = 1'b0;
               end else if (f_gnt) begin
                  if (fetch_req && rnd_phase && $urandom_range(0, 15) == 0) fetch_req = 1'b0;
                  pc_addr = 8'($urandom);
               end else if (fetch_req) begin
                  if (rnd_phase && $urandom_range(0, 15) == 0) fetch_req = 1'b0;
               end else if (!rnd_phase || $urandom_range(0, 2) == 0) begin
                  fetch_req = 1'b1;
                  if (rnd_phase) pc_addr = 8'($urandom_range(0, 63));
                  else begin
                     pc_addr = f_tab[fi % 4];
                     fi++;
                  end
               end

               if (e.dack) begin
                  d_gnt  = 1'b0;
                  d_drop = 1'b1;
               end else if (d_drop) begin
                  data_req = 1'b0;
                  d_drop   = 1'b0;
               end else if (d_gnt) begin
                  if (data_req && rnd_phase && $urandom_range(0, 15) == 0) data_req = 1'b0;
                  data_addr  = 16'($urandom);
                  data_wdata = $urandom;
                  data_we    = 1'($urandom_range(0, 1));
               end else if (data_req) begin
                  if (rnd_phase && $urandom_range(0, 15) == 0) data_req = 1'b0;
               end else if (!rnd_phase || $urandom_range(0, 2) == 0) begin
                  data_req = 1'b1;
                  if (rnd_phase) begin
                     data_we    = 1'($urandom_range(0, 1));
                     data_addr  = 16'($urandom_range(0, 63));
                     data_wdata = $urandom;
                  end else begin
                     data_we    = d_we_tab[di % 4];
                     data_addr  = d_addr_tab[di % 4];
                     data_wdata = d_wd_tab[di % 4];
                     di++;
                  end
               end
            end

            // Reference arbitration: expand a grant into its per-cycle bus trace
            if (rst) begin
               q.delete();
               last_data = 1'b0;
            end else if (cur_idle && (fetch_req || data_req)) begin
               gd        = data_req && (!fetch_req || !last_data);
               last_data = gd;
               if (gd) d_gnt = 1'b1;
               else    f_gnt = 1'b1;
               a  = gd ? data_addr : {8'h00, pc_addr};
               wr = gd && data_we;
               t          = '0;
               t.busy     = 1'b1;
               t.sel      = gd;
               t.addr     = a;
               t.chk_addr = 1'b1;
               if (wr) begin
                  mdl_mem[a]  = data_wdata;
                  t.we        = 1'b1;
                  t.wdata     = data_wdata;
                  t.chk_wdata = 1'b1;
                  q.push_back(t);
                  t.we        = 1'b0;
                  t.chk_wdata = 1'b0;
                  t.dack      = 1'b1;
                  q.push_back(t);
               end else begin
                  rv   = mdl_mem.exists(a) ? mdl_mem[a] : seed_val(a);
                  t.re = 1'b1;
                  q.push_back(t);
                  t.re = 1'b0;
                  for (int w = 1; w < LAT; w++) q.push_back(t);
                  t.rval   = rv;
                  t.upd_rd = 1'b1;
                  if (gd) t.dack = 1'b1;
                  else    t.fack = 1'b1;
                  q.push_back(t);
               end
            end
            rst_prev = rst;
         end
         done_f = 1'b1;
      end
   end

   initial begin
      for (int c = 0; c < NCYC + 200; c++) begin
         @(posedge clk);
         if (g_lat[0].done_f && g_lat[1].done_f && g_lat[2].done_f) break;
      end
      check_eq("run_complete", {29'd0, g_lat[2].done_f, g_lat[1].done_f, g_lat[0].done_f}, 32'h7);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
